data_ram_sb: RTL
================

DATA_RAM_SB -- requirements
Module: data_ram_sb

Interface
REQ-001 Parameter: ADDR_W, default 10, word-index width; the array holds 2^ADDR_W 32-bit words.
REQ-002 Parameter: SB_DEPTH, default 4, store-buffer entries; power of two, at least 2.
REQ-003 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Port: ce_i  input  1  data-memory access request from the CPU MEM stage.
REQ-006 Port: we_i  input  1  1 = store, 0 = load; qualified by ce_i.
REQ-007 Port: addr_i  input  32  byte address; only bits [ADDR_W+1:2] are used.
REQ-008 Port: sel_i  input  4  byte enables; sel_i[3] is byte lane [31:24] (big-endian lane order, matching the CPU's sel encoding).
REQ-009 Port: data_i  input  32  store data, lane-aligned.
REQ-010 Port: data_o  output  32  load data, combinational.
REQ-011 Port: stallreq_o  output  1  combinational pipeline-stall request toward ctrl.
REQ-012 Port: idle_o  output  1  high when the store buffer is empty.

Function
REQ-013 Index: idx = addr_i[ADDR_W+1:2]; upper address bits are ignored, so addresses alias (wrap-around).
REQ-014 Store buffer: circular FIFO of SB_DEPTH entries, each holding {idx, sel, data}.
REQ-015 FIFO state: wr_ptr and rd_ptr wrap modulo SB_DEPTH; count ranges 0..SB_DEPTH.
REQ-016 Store accept: a store is ce_i=1 and we_i=1; when count<SB_DEPTH at cycle start, the entry is enqueued at the clock edge and stallreq_o=0.
REQ-017 Store refuse: when a store arrives with count==SB_DEPTH, stallreq_o=1 in the same cycle, nothing is enqueued, and the CPU holds the request.
REQ-018 stallreq_o is 0 for loads and for idle cycles.
REQ-019 Array port: the array has a single port; any cycle with ce_i=1 owns that port.
REQ-020 Drain: on a cycle with ce_i=0 and count>0, the entry at rd_ptr is written into the array; only bytes with sel=1 are written; rd_ptr advances.
REQ-021 Drain is never performed on a cycle with ce_i=1.
REQ-022 Simultaneous events: enqueue and drain cannot coincide, because drain requires ce_i=0; count changes by at most ±1 per cycle.
REQ-023 Load data: with ce_i=1 and we_i=0, data_o is built per byte lane.
REQ-024 Load forwarding: for each lane, data_o takes the newest valid buffer entry with matching idx and that lane's sel=1; otherwise it takes the array byte.
REQ-025 Load sel: sel_i is ignored for loads; the full forwarded word is returned and the CPU extracts lanes.
REQ-026 data_o is 0 when ce_i=0 or we_i=1.
REQ-027 Ordering: stores to the same idx take effect in program order; a later entry's bytes override earlier ones, both on drain and on forwarding.
REQ-028 idle_o = (count==0).

Reset
REQ-029 While rst=0: count=0, wr_ptr=0, rd_ptr=0, stallreq_o=0, data_o=0, idle_o=1.
REQ-030 Reset mid-operation discards all pending buffer entries; they are never written to the array.
REQ-031 Array contents are not reset and are undefined until written.
REQ-032 Buffer payload registers need no reset; they are qualified by count.

Structure
REQ-033 Shared defines file: RegBus width, ChipEnable/WriteEnable encodings and the default ADDR_W and SB_DEPTH constants.
REQ-034 One natural sub-module, sb_fifo: pointers, count, entry storage, and the forwarding-match vector output.
REQ-035 The array and the lane-merge logic stay in data_ram_sb.

Verification
REQ-036 Forwarding: store idx 5 sel=1111 data=0x11223344, then load idx 5 on the next cycle with no idle cycle -> data_o=0x11223344 from the buffer; idle_o=0.
REQ-037 Byte merge: array[7]=0xAABBCCDD; store idx 7 sel=0100 data=0x00EE0000 -> load idx 7 returns 0xAAEECCDD; after one ce_i=0 cycle array[7]=0xAAEECCDD and idle_o=1.
REQ-038 Full: 4 back-to-back stores (idx 0..3) -> stallreq_o=0; a 5th store -> stallreq_o=1, count stays 4; drop ce_i for 1 cycle, then re-issue -> accepted, stallreq_o=0.
REQ-039 Ordering: store idx 9 data 0x1, then 0x2, then 0x3 (sel=1111), then drain 3 cycles -> array[9]=0x3; a load of idx 9 before draining returns 0x3.
REQ-040 Reset mid-operation: 3 entries pending, assert rst=0 asynchronously between edges -> idle_o=1 immediately; after release, the array is unchanged at those indices.
REQ-041 Aliasing: store addr 0x00001010 with ADDR_W=10 -> a load of addr 0x00000010 returns the stored word.

Source files
------------

// File: rtl/data_ram_sb_pkg.sv
// Shared constants for the buffered data RAM.
// Bus width, enable encodings, default geometry.
package data_ram_sb_pkg;

  localparam int REG_BUS_W    = 32;
  localparam int ADDR_W_DEF   = 10;
  localparam int SB_DEPTH_DEF = 4;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;

  typedef logic [REG_BUS_W-1:0] reg_bus_t;
  typedef logic [3:0]           sel_t;

endpackage

// File: rtl/data_ram_sb_if.sv
// MEM-stage <-> data RAM bus.
// master = CPU side, slave = data_ram_sb.
interface data_ram_sb_if;
  import data_ram_sb_pkg::*;

  logic     ce_i;
  logic     we_i;
  logic [31:0] addr_i;
  sel_t     sel_i;
  reg_bus_t data_i;
  reg_bus_t data_o;
  logic     stallreq_o;
  logic     idle_o;

  modport master (
    output ce_i, we_i, addr_i, sel_i, data_i,
    input  data_o, stallreq_o, idle_o
  );

  modport slave (
    input  ce_i, we_i, addr_i, sel_i, data_i,
    output data_o, stallreq_o, idle_o
  );

endinterface

// File: rtl/sb_fifo.sv
// Store-buffer FIFO: pointers, count, payload.
// Ports: push/pop, head entry, per-age match/sel/data.
module sb_fifo
  import data_ram_sb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int SB_DEPTH = SB_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_push,
  input  logic [ADDR_W-1:0]         i_idx,
  input  sel_t                      i_sel,
  input  reg_bus_t                  i_data,
  input  logic                      i_pop,
  input  logic [ADDR_W-1:0]         i_lkp_idx,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [ADDR_W-1:0]         o_head_idx,
  output sel_t                      o_head_sel,
  output reg_bus_t                  o_head_data,
  output logic [SB_DEPTH-1:0]       o_match,
  output sel_t [SB_DEPTH-1:0]       o_age_sel,
  output reg_bus_t [SB_DEPTH-1:0]   o_age_data
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [ADDR_W-1:0] r_idx  [SB_DEPTH];
  sel_t              r_sel  [SB_DEPTH];
  reg_bus_t          r_data [SB_DEPTH];

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CW'(SB_DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case (1'b1)
        w_push & ~w_pop: r_count <= r_count + 1'b1;
        w_pop & ~w_push: r_count <= r_count - 1'b1;
        default:         r_count <= r_count;
      endcase
    end
  end

  // Payload is qualified by count, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_idx[r_wr_ptr]  <= i_idx;
      r_sel[r_wr_ptr]  <= i_sel;
      r_data[r_wr_ptr] <= i_data;
    end
  end

  assign o_head_idx  = r_idx[r_rd_ptr];
  assign o_head_sel  = r_sel[r_rd_ptr];
  assign o_head_data = r_data[r_rd_ptr];

  // Entries presented by age: slot 0 oldest.
  always_comb begin
    logic [PW-1:0] slot;
    slot       = '0;
    o_match    = '0;
    o_age_sel  = '0;
    o_age_data = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      slot          = r_rd_ptr + PW'(k);
      o_match[k]    = (CW'(k) < r_count) &&
                      (r_idx[slot] == i_lkp_idx);
      o_age_sel[k]  = r_sel[slot];
      o_age_data[k] = r_data[slot];
    end
  end

endmodule

// File: rtl/data_ram_sb.sv
// Single-port data RAM behind a store buffer.
// Ports: clk, rst (async low), bus (slave).
module data_ram_sb
  import data_ram_sb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int SB_DEPTH = SB_DEPTH_DEF
) (
  input  logic           clk,
  input  logic           rst,
  data_ram_sb_if.slave   bus
);

  logic [ADDR_W-1:0]       w_idx;
  logic [31-ADDR_W:0]      w_unused_addr;
  logic                    w_store;
  logic                    w_load;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic [ADDR_W-1:0]       w_head_idx;
  sel_t                    w_head_sel;
  reg_bus_t                w_head_data;
  logic [SB_DEPTH-1:0]     w_match;
  sel_t [SB_DEPTH-1:0]     w_age_sel;
  reg_bus_t [SB_DEPTH-1:0] w_age_data;
  reg_bus_t                w_arr;
  reg_bus_t                w_fwd;

  reg_bus_t r_mem [0:(1<<ADDR_W)-1];

  assign w_idx         = bus.addr_i[ADDR_W+1:2];
  assign w_unused_addr = {bus.addr_i[31:ADDR_W+2],
                          bus.addr_i[1:0]};

  assign w_store = rst &
                   (bus.ce_i == CHIP_ENABLE) &
                   (bus.we_i == WRITE_ENABLE);
  assign w_load  = rst &
                   (bus.ce_i == CHIP_ENABLE) &
                   (bus.we_i != WRITE_ENABLE);

  assign w_push = w_store & ~w_full;
  // Drain only when the CPU leaves the array port free.
  assign w_pop  = rst & (bus.ce_i != CHIP_ENABLE) & ~w_empty;

  sb_fifo #(
    .ADDR_W   (ADDR_W),
    .SB_DEPTH (SB_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_idx       (w_idx),
    .i_sel       (bus.sel_i),
    .i_data      (bus.data_i),
    .i_pop       (w_pop),
    .i_lkp_idx   (w_idx),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head_idx  (w_head_idx),
    .o_head_sel  (w_head_sel),
    .o_head_data (w_head_data),
    .o_match     (w_match),
    .o_age_sel   (w_age_sel),
    .o_age_data  (w_age_data)
  );

  always_ff @(posedge clk) begin
    if (w_pop) begin
      for (int b = 0; b < 4; b++) begin
        if (w_head_sel[b])
          r_mem[w_head_idx][8*b +: 8] <= w_head_data[8*b +: 8];
      end
    end
  end

  assign w_arr = r_mem[w_idx];

  // Walk oldest to newest so younger bytes win.
  always_comb begin
    w_fwd = w_arr;
    for (int k = 0; k < SB_DEPTH; k++) begin
      for (int b = 0; b < 4; b++) begin
        if (w_match[k] && w_age_sel[k][b])
          w_fwd[8*b +: 8] = w_age_data[k][8*b +: 8];
      end
    end
  end

  assign bus.data_o     = w_load ? w_fwd : '0;
  assign bus.stallreq_o = w_store & w_full;
  assign bus.idle_o     = w_empty;

endmodule
